loa_ram_reader: RTL

LOA_RAM_READER -- requirements
Module: loa_ram_reader

---
 rtl/loa_pkg.sv | 19 +
 rtl/loa_rd_fifo.sv | 73 +++++++
 rtl/loa_ram_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/loa_pkg.sv
// Shared definitions for the logic-analyzer capture RAM readout path.
package loa_pkg;

    localparam int LOA_ADDR_W  = 15;
    localparam int LOA_DATA_W  = 8;
    localparam int LOA_DECIM_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } loa_state_e;

    // Sample count with 0 standing for the full 2^addr_w capture.
    function automatic logic [LOA_ADDR_W:0] loa_full_len(input logic [LOA_ADDR_W-1:0] len);
        return (len == '0) ? {1'b1, {LOA_ADDR_W{1'b0}}} : {1'b0, len};
    endfunction

endpackage

// File: rtl/loa_rd_fifo.sv
// Small synchronous first-word-fall-through FIFO buffering RAM samples
// toward the stream output; flush empties it in one cycle.
module loa_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        do_wr  = 1'b0;
        do_rd  = 1'b0;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            do_wr = wr_en && (cnt_q != CW'(DEPTH));
            do_rd = rd_en && (cnt_q != '0);
            if (do_wr) begin
                mem_d[wptr_q] = wr_data;
                wptr_d        = ptr_inc(wptr_q);
            end
            if (do_rd) begin
                rptr_d = ptr_inc(rptr_q);
            end
            cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Head is zeroed when empty so the stream data reads 0 while idle.
    assign valid   = (cnt_q != '0);
    assign rd_data = valid ? mem_q[rptr_q] : '0;
    assign count   = cnt_q;

endmodule

// File: rtl/loa_ram_reader.sv
// Streams a window of the capture RAM out through a ready/valid port.
// Optional macro LOA_READER_DECIM_EN adds a decim input (address stride decim+1).
module loa_ram_reader
    import loa_pkg::*;
#(
    parameter int ADDR_W     = LOA_ADDR_W,
    parameter int DATA_W     = LOA_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef LOA_READER_DECIM_EN
    input  logic [LOA_DECIM_W-1:0] decim,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    loa_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic [ADDR_W:0]   out_left_q, out_left_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W:0]   len_full;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occ_sum;
    logic              start_ok, abort_ok, issue, xfer;

`ifdef LOA_READER_DECIM_EN
    logic [ADDR_W-1:0] step_q, step_d;
    assign step = step_q;
`else
    assign step = ADDR_W'(1);
`endif

    always_comb begin
        len_full = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length};
    end

    // Occupancy plus the read whose data lands next cycle; the headroom keeps
    // the FIFO from ever overflowing when the sink stalls.
    assign occ_sum  = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    assign start_ok = (state_q == ST_IDLE) && start && !abort;
    assign abort_ok = (state_q != ST_IDLE) && abort;
    assign issue    = (state_q == ST_READ) && !abort && (occ_sum <= (CW + 1)'(FIFO_DEPTH - 2));
    assign xfer     = out_valid && out_ready;
    assign out_last = out_valid && (out_left_q == (ADDR_W + 1)'(1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        inflight_d = issue;
        done_d     = xfer && out_last && !abort_ok;
`ifdef LOA_READER_DECIM_EN
        step_d     = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_READ;
                    addr_d     = start_addr;
                    rd_left_d  = len_full;
                    out_left_d = len_full;
`ifdef LOA_READER_DECIM_EN
                    step_d     = ADDR_W'(decim) + ADDR_W'(1);
`endif
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d    = addr_q + step;
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && out_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (xfer && state_q != ST_IDLE) begin
            out_left_d = out_left_q - 1'b1;
        end
        // Abort drops the data of any read still in flight.
        if (abort_ok) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOA_READER_DECIM_EN
            step_q     <= ADDR_W'(1);
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
`ifdef LOA_READER_DECIM_EN
            step_q     <= step_d;
`endif
        end
    end

    loa_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk_50M),
        .rst     (rst),
        .flush   (abort_ok),
        .wr_en   (inflight_q),
        .wr_data (rd_data),
        .rd_en   (xfer),
        .rd_data (out_data),
        .valid   (out_valid),
        .count   (fifo_count)
    );

    assign rd_en   = issue;
    assign rd_addr = addr_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule
